// File: rtl/ser_tx_framer.sv
// 8b/10b transmit framer: idle ordered sets, K-char delimited packets, abort on underrun.
// Symbols are {a,b,c,d,e,i,f,g,h,j} with 'a' (first on the wire) in bit 9.

module encode_8b10b (
  input  logic       i_k,
  input  logic [7:0] i_data,
  input  logic       i_rd,
  output logic [9:0] o_sym,
  output logic       o_rd
);

  // 5b/6b codes for negative running disparity (abcdei)
  function automatic logic [5:0] f_6b_neg(input logic [4:0] x);
    case (x)
      5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
      5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
      5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
      5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
      5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
      5'd10: return 6'b010101;  5'd11: return 6'b110100;
      5'd12: return 6'b001101;  5'd13: return 6'b101100;
      5'd14: return 6'b011100;  5'd15: return 6'b010111;
      5'd16: return 6'b011011;  5'd17: return 6'b100011;
      5'd18: return 6'b010011;  5'd19: return 6'b110010;
      5'd20: return 6'b001011;  5'd21: return 6'b101010;
      5'd22: return 6'b011010;  5'd23: return 6'b111010;
      5'd24: return 6'b110011;  5'd25: return 6'b100110;
      5'd26: return 6'b010110;  5'd27: return 6'b110110;
      5'd28: return 6'b001110;  5'd29: return 6'b101110;
      5'd30: return 6'b011110;  5'd31: return 6'b101011;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [3:0] f_4b_neg(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011;  3'd1: return 4'b1001;
      3'd2: return 4'b0101;  3'd3: return 4'b1100;
      3'd4: return 4'b1101;  3'd5: return 4'b1010;
      3'd6: return 4'b0110;  3'd7: return 4'b1110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic f_unbal6(input logic [5:0] c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, c[i]};
    return (n != 3'd3);
  endfunction

  function automatic logic f_unbal4(input logic [3:0] c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, c[i]};
    return (n != 3'd2);
  endfunction

  logic [4:0] w_x;
  logic [2:0] w_y;
  logic       w_k28;
  logic [5:0] w_6b_base;
  logic [5:0] w_6b;
  logic       w_6b_unbal;
  logic       w_rd6;
  logic       w_a7;
  logic [3:0] w_4b_base;
  logic [3:0] w_4b;
  logic       w_4b_unbal;
  logic       w_k28_flip;

  assign w_x        = i_data[4:0];
  assign w_y        = i_data[7:5];
  assign w_k28      = i_k & (w_x == 5'd28);
  assign w_6b_base  = w_k28 ? 6'b001111 : f_6b_neg(w_x);
  assign w_6b_unbal = f_unbal6(w_6b_base);
  // D.07 is balanced yet still alternates with disparity
  assign w_6b       = (i_rd & (w_6b_unbal | (w_x == 5'd7))) ? ~w_6b_base : w_6b_base;
  assign w_rd6      = i_rd ^ w_6b_unbal;

  // Alternate x.7 avoids a run of five equal bits across the 6b/4b boundary
  assign w_a7 = (w_y == 3'd7) &
                (i_k |
                 (~w_rd6 & ((w_x == 5'd17) | (w_x == 5'd18) | (w_x == 5'd20))) |
                 ( w_rd6 & ((w_x == 5'd11) | (w_x == 5'd13) | (w_x == 5'd14))));
  assign w_4b_base  = w_a7 ? 4'b0111 : f_4b_neg(w_y);
  assign w_4b_unbal = f_unbal4(w_4b_base);
  // K28 balanced 4b groups are the complement of the data form
  assign w_k28_flip = w_k28 & ~w_rd6 & ~w_4b_unbal & (w_y != 3'd3);
  assign w_4b       = ((w_rd6 & (w_4b_unbal | (w_y == 3'd3))) | w_k28_flip) ? ~w_4b_base : w_4b_base;

  assign o_sym = {w_6b, w_4b};
  assign o_rd  = w_rd6 ^ w_4b_unbal;

endmodule

module ser_tx_framer #(
  parameter int MIN_IDLE = 2,
  parameter int GAP_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] data_i,
  input  logic       sop_i,
  input  logic       eop_i,
  input  logic       src_rdy_i,
  output logic       dst_rdy_o,
  output logic [9:0] sym_o,
  output logic       disp_o,
  output logic       in_pkt_o,
  output logic       underrun_o,
  output logic       drop_o
);

  localparam logic [8:0] L_K28_5 = 9'h1BC;
  localparam logic [8:0] L_D5_6  = 9'h0C5;
  localparam logic [8:0] L_D16_2 = 9'h050;
  localparam logic [8:0] L_K27_7 = 9'h1FB;
  localparam logic [8:0] L_K29_7 = 9'h1FD;
  localparam logic [8:0] L_K30_7 = 9'h1FE;
  localparam logic [GAP_W-1:0] L_MIN_GAP = GAP_W'(MIN_IDLE);
  localparam logic [GAP_W-1:0] L_GAP_MAX = {GAP_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE_K = 3'd0,
    S_IDLE_D = 3'd1,
    S_SOP    = 3'd2,
    S_DATA   = 3'd3,
    S_EOP    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [GAP_W-1:0] w_gap_inc;
  logic             r_drain;
  logic             w_drain_set;
  logic             w_drain_nxt;
  logic [9:0]       r_sym;
  logic             r_disp;
  logic             r_in_pkt;
  logic             r_underrun;
  logic             r_drop;
  logic [8:0]       w_code;
  logic             w_rdy;
  logic             w_dst_rdy;
  logic             w_accept;
  logic             w_drop;
  logic             w_underrun;
  logic             w_in_pkt;
  logic [9:0]       w_enc_sym;
  logic             w_enc_rd;

  encode_8b10b u_enc (
    .i_k    (w_code[8]),
    .i_data (w_code[7:0]),
    .i_rd   (r_disp),
    .o_sym  (w_enc_sym),
    .o_rd   (w_enc_rd)
  );

  assign w_gap_inc = (r_gap == L_GAP_MAX) ? r_gap : r_gap + {{(GAP_W-1){1'b0}}, 1'b1};

  always_comb begin
    w_state_nxt = r_state;
    w_code      = L_K28_5;
    w_rdy       = 1'b0;
    w_gap_nxt   = r_gap;
    w_drain_set = 1'b0;
    w_underrun  = 1'b0;
    case (r_state)
      S_IDLE_K: begin
        // Outside drain, only non-head bytes are swallowed here
        w_rdy       = r_drain | (src_rdy_i & ~sop_i);
        w_state_nxt = S_IDLE_D;
      end
      S_IDLE_D: begin
        w_code    = r_disp ? L_D16_2 : L_D5_6;
        w_rdy     = r_drain;
        w_gap_nxt = w_gap_inc;
        if (enable & ~r_drain & (w_gap_inc >= L_MIN_GAP) & src_rdy_i & sop_i) begin
          w_state_nxt = S_SOP;
        end else begin
          w_state_nxt = S_IDLE_K;
        end
      end
      S_SOP: begin
        w_code      = L_K27_7;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_rdy = 1'b1;
        if (src_rdy_i) begin
          w_code = {1'b0, data_i};
          if (eop_i) begin
            w_state_nxt = S_EOP;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_code      = L_K30_7;
          w_underrun  = 1'b1;
          w_drain_set = 1'b1;
          w_gap_nxt   = {GAP_W{1'b0}};
          w_state_nxt = S_IDLE_K;
        end
      end
      S_EOP: begin
        w_code      = L_K29_7;
        w_gap_nxt   = {GAP_W{1'b0}};
        w_state_nxt = S_IDLE_K;
      end
      default: begin
        w_state_nxt = S_IDLE_K;
      end
    endcase
  end

  // Nothing is accepted while reset is held
  assign w_dst_rdy   = w_rdy & ~rst;
  assign w_accept    = src_rdy_i & w_dst_rdy;
  assign w_drop      = w_accept & ((r_state == S_IDLE_K) | (r_state == S_IDLE_D));
  assign w_drain_nxt = w_drain_set | (r_drain & ~(w_accept & eop_i));
  assign w_in_pkt    = (r_state == S_SOP) | (r_state == S_DATA) | (r_state == S_EOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE_K;
      r_gap      <= L_MIN_GAP;
      r_drain    <= 1'b0;
      r_sym      <= 10'd0;
      r_disp     <= 1'b0;
      r_in_pkt   <= 1'b0;
      r_underrun <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gap      <= w_gap_nxt;
      r_drain    <= w_drain_nxt;
      r_sym      <= w_enc_sym;
      r_disp     <= w_enc_rd;
      r_in_pkt   <= w_in_pkt;
      r_underrun <= w_underrun;
      r_drop     <= w_drop;
    end
  end

  assign dst_rdy_o  = w_dst_rdy;
  assign sym_o      = r_sym;
  assign disp_o     = r_disp;
  assign in_pkt_o   = r_in_pkt;
  assign underrun_o = r_underrun;
  assign drop_o     = r_drop;

endmodule
